// File: rtl/fsm101_frame_ctrl_if.sv
// rtl/fsm101_frame_ctrl_if.sv - host/bit-source bundle for the framed "101" detector
// Optional abort/aborted signals exist only when FSM101_ABORT_EN is defined.
interface fsm101_frame_ctrl_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             overlap;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             hit;
  logic [CNT_W-1:0] hit_cnt;
  logic             ovf;
  logic             done;
`ifdef FSM101_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output start, frame_len, overlap, x, x_valid, abort,
    input  busy, hit, hit_cnt, ovf, done, aborted
  );

  modport slave (
    input  start, frame_len, overlap, x, x_valid, abort,
    output busy, hit, hit_cnt, ovf, done, aborted
  );
`else
  modport master (
    output start, frame_len, overlap, x, x_valid,
    input  busy, hit, hit_cnt, ovf, done
  );

  modport slave (
    input  start, frame_len, overlap, x, x_valid,
    output busy, hit, hit_cnt, ovf, done
  );
`endif
endinterface

// File: rtl/fsm101_frame_ctrl.sv
// rtl/fsm101_frame_ctrl.sv - bounded-frame "101" detector with saturating hit count
// Optional feature macro: FSM101_ABORT_EN (adds abort input and aborted flag).
module fsm101_frame_ctrl #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm101_frame_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_t;

  ctrl_t            ctrl;
  det_t             det;
  logic [LEN_W-1:0] bits_left;
  logic             overlap_q;
  logic             busy_q;
  logic             hit_q;
  logic             done_q;
  logic             ovf_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic             match;

  // S3 differs by mode: overlapping reuses the trailing '1' as a new "1".
  function automatic det_t det_next(input det_t d, input logic b, input logic ovl);
    case (d)
      S0:      return b ? S1 : S0;
      S1:      return b ? S1 : S2;
      S2:      return b ? S3 : S0;
      default: return b ? S1 : (ovl ? S2 : S0);
    endcase
  endfunction

  assign match = (det == S2) && bus.x;

`ifdef FSM101_ABORT_EN
  logic aborted_q;
  assign bus.aborted = aborted_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= IDLE;
      det       <= S0;
      bits_left <= '0;
      overlap_q <= 1'b0;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      hit_cnt_q <= '0;
`ifdef FSM101_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      hit_q  <= 1'b0;
      done_q <= 1'b0;
      case (ctrl)
        IDLE: begin
          if (bus.start) begin
            hit_cnt_q <= '0;
            ovf_q     <= 1'b0;
`ifdef FSM101_ABORT_EN
            aborted_q <= 1'b0;
`endif
            if (bus.frame_len != '0) begin
              ctrl      <= RUN;
              busy_q    <= 1'b1;
              bits_left <= bus.frame_len;
              overlap_q <= bus.overlap;
              det       <= S0;
            end else begin
              ctrl   <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
`ifdef FSM101_ABORT_EN
          if (bus.abort) begin
            ctrl      <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else
`endif
          if (bus.x_valid) begin
            det       <= det_next(det, bus.x, overlap_q);
            bits_left <= bits_left - 1'b1;
            if (match) begin
              hit_q <= 1'b1;
              if (&hit_cnt_q) ovf_q <= 1'b1;
              else            hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            // done is raised on the same edge as the last hit so both are seen together.
            if (bits_left == LEN_W'(1)) begin
              ctrl   <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE:    ctrl <= IDLE;
        default: ctrl <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.hit     = hit_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_fsm101_frame_ctrl.sv
// tb/tb_fsm101_frame_ctrl.sv - randomized self-checking bench for fsm101_frame_ctrl
module tb_fsm101_frame_ctrl;
  localparam int LEN_W   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsm101_frame_ctrl_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus();
  fsm101_frame_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.overlap   = 1'b0;
    bus.x         = 1'b0;
    bus.x_valid   = 1'b0;
`ifdef FSM101_ABORT_EN
    bus.abort     = 1'b0;
`endif
  endtask

  // Frame driver: expected matches come from a sliding 3-bit window over the bit list.
  task automatic run_frame(input int len, input logic ovl, input logic [254:0] bits,
                           input int gap, input bit noise);
    int cnt = 0;
    int last_end = -1;
    int g;
    int exp_cnt = 0;
    bit exp_ovf = 0;
    bit m;
    bus.start = 1'b1; bus.frame_len = LEN_W'(len); bus.overlap = ovl;
    step();
    bus.start = 1'b0; bus.frame_len = LEN_W'($urandom); bus.overlap = 1'($urandom);
    n_tests++; if (bus.busy !== (len != 0)) begin n_fail++; $display("FAIL start_busy len=%0d: got %b exp %b", len, bus.busy, (len != 0)); end
    n_tests++; if (bus.done !== (len == 0)) begin n_fail++; $display("FAIL start_done len=%0d: got %b exp %b", len, bus.done, (len == 0)); end
    n_tests++; if (bus.hit_cnt !== '0) begin n_fail++; $display("FAIL start_cnt_clr: got %0d exp 0", bus.hit_cnt); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL start_ovf_clr: got %b exp 0", bus.ovf); end
    for (int k = 0; k < len; k++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int j = 0; j < g; j++) begin
        bus.x_valid = 1'b0; bus.x = 1'($urandom);
        if (noise) begin bus.start = 1'($urandom); bus.frame_len = LEN_W'($urandom); end
        step();
        bus.start = 1'b0;
        n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL gap_hit bit%0d: got %b exp 0", k, bus.hit); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL gap_done bit%0d: got %b exp 0", k, bus.done); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy bit%0d: got %b exp 1", k, bus.busy); end
      end
      bus.x = bits[k]; bus.x_valid = 1'b1;
      step();
      bus.x_valid = 1'b0;
      m = 1'b0;
      if (k >= 2) m = bits[k-2] && !bits[k-1] && bits[k] && (ovl || (k - 2 > last_end));
      if (m) begin last_end = k; cnt++; end
      exp_cnt = (cnt > CNT_MAX) ? CNT_MAX : cnt;
      exp_ovf = (cnt > CNT_MAX);
      n_tests++; if (bus.hit !== m) begin n_fail++; $display("FAIL hit bit%0d: got %b exp %b", k, bus.hit, m); end
      n_tests++; if (bus.hit_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL hit_cnt bit%0d: got %0d exp %0d", k, bus.hit_cnt, exp_cnt); end
      n_tests++; if (bus.ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf bit%0d: got %b exp %b", k, bus.ovf, exp_ovf); end
      n_tests++; if (bus.done !== (k == len - 1)) begin n_fail++; $display("FAIL done bit%0d: got %b exp %b", k, bus.done, (k == len - 1)); end
      n_tests++; if (bus.busy !== (k != len - 1)) begin n_fail++; $display("FAIL busy bit%0d: got %b exp %b", k, bus.busy, (k != len - 1)); end
`ifdef FSM101_ABORT_EN
      if (k == len - 1) begin
        n_tests++; if (bus.aborted !== 1'b0) begin n_fail++; $display("FAIL aborted_normal: got %b exp 0", bus.aborted); end
      end
`endif
    end
    if (noise) begin bus.start = 1'b1; bus.frame_len = LEN_W'(7); end
    step();
    bus.start = 1'b0;
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL post_done: got %b exp 0", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_busy: got %b exp 0", bus.busy); end
    n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL post_hit: got %b exp 0", bus.hit); end
    n_tests++; if (bus.hit_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL post_cnt_hold: got %0d exp %0d", bus.hit_cnt, exp_cnt); end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    bus.x = 1'b0; step();
    bus.x = 1'b1; step();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b exp 0", bus.hit); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b exp 0", bus.done); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b exp 0", bus.ovf); end
    n_tests++; if (bus.hit_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", bus.hit_cnt); end
    rst = 1'b0;
    bus.start = 1'b1; bus.frame_len = LEN_W'(4);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.x = 1'($urandom);
      step();
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy cyc%0d: got %b exp 1", i, bus.busy); end
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL stall_done cyc%0d: got %b exp 0", i, bus.done); end
    end
    rst = 1'b1; step(); rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_overlap();
    run_frame(5, 1'b1, 255'b10101, 0, 0);
  endtask

  task automatic test_nonoverlap();
    run_frame(5, 1'b0, 255'b10101, 0, 0);
  endtask

  task automatic test_gaps();
    run_frame(3, 1'b1, 255'b101, 2, 1);
  endtask

  task automatic test_saturation();
    run_frame(13, 1'b1, 255'b1010101010101, 0, 0);
    run_frame(3, 1'b1, 255'b000, 0, 0);
  endtask

  task automatic test_reset_midframe();
    bus.start = 1'b1; bus.frame_len = LEN_W'(5); bus.overlap = 1'b1;
    step();
    bus.start = 1'b0;
    bus.x_valid = 1'b1;
    bus.x = 1'b1; step();
    bus.x = 1'b0; step();
    bus.x = 1'b1; rst = 1'b1; step();
    rst = 1'b0; bus.x_valid = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", bus.busy); end
    n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL midrst_hit: got %b exp 0", bus.hit); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b exp 0", bus.done); end
    n_tests++; if (bus.hit_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt: got %0d exp 0", bus.hit_cnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_nodone cyc%0d: got %b exp 0", i, bus.done); end
    end
    run_frame(0, 1'b0, 255'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [254:0] bits;
    int len;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(0, 60);
      for (int i = 0; i < 255; i++) bits[i] = ($urandom_range(0, 2) != 0);
      run_frame(len, 1'($urandom), bits, -1, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    run_frame(6, 1'b0, 255'b101101, 0, 1);
    run_frame(1, 1'b1, 255'b1, 0, 1);
    run_frame(7, 1'b1, 255'b1010110, 0, 1);
  endtask

`ifdef FSM101_ABORT_EN
  task automatic test_abort();
    bus.start = 1'b1; bus.frame_len = LEN_W'(10); bus.overlap = 1'b1;
    step();
    bus.start = 1'b0; bus.x_valid = 1'b1;
    bus.x = 1'b1; step();
    bus.x = 1'b0; step();
    bus.x = 1'b1; step();
    bus.x = 1'b0; bus.abort = 1'b1;
    n_tests++; if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL abort_pending_hit: got %b exp 1", bus.hit); end
    step();
    bus.abort = 1'b0; bus.x_valid = 1'b0;
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b exp 1", bus.done); end
    n_tests++; if (bus.aborted !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b exp 1", bus.aborted); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", bus.busy); end
    n_tests++; if (bus.hit_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL abort_cnt: got %0d exp 1", bus.hit_cnt); end
    step();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done_pulse: got %b exp 0", bus.done); end
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_saturation();
    test_reset_midframe();
    test_back_to_back();
`ifdef FSM101_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
